// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and shadow types for the hazard controller
package hazard_pkg;

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef struct packed {
    logic [4:0] dest;
    logic       we;
    logic       load;
    logic       mem;
  } em_shadow_t;

  typedef struct packed {
    logic [4:0] dest;
    logic       we;
  } wb_shadow_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// rtl/pipeline_hazard_ctrl_fwd_select.sv - per-operand EM/WB match and forwarding priority
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] em_dest,
  input  logic       em_we,
  input  logic       em_load,
  input  logic [4:0] wb_dest,
  input  logic       wb_we,
  output logic       load_use,
  output logic [1:0] sel
);

  logic match_em;
  logic match_wb;

  // $0 is hardwired, so it can never be a hazard source
  always_comb begin
    match_em = use_src && em_we && (em_dest == src) && (src != 5'd0);
    match_wb = use_src && wb_we && (wb_dest == src) && (src != 5'd0);
    load_use = match_em && em_load;
    if (match_em && !em_load) begin
      sel = FWD_EM;
    end else if (match_wb) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, forwarding and stall control for the 4-stage pipeline
// Forwarding is built only when HAZARD_FWD_EN is defined; otherwise every dependency stalls.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_we,
  input  logic             id_mem_re,
  input  logic             id_mem_we,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_em,
  output logic             stall_em,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        state_q, state_d;
  em_shadow_t        em_q, em_d;
  wb_shadow_t        wb_q, wb_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic [1:0] sel_rs, sel_rt;
  logic       lu_rs, lu_rt;
  logic       freeze, interlock;

  fwd_select u_fwd_rs (
    .src      (id_rs),
    .use_src  (id_use_rs),
    .em_dest  (em_q.dest),
    .em_we    (em_q.we),
    .em_load  (em_q.load),
    .wb_dest  (wb_q.dest),
    .wb_we    (wb_q.we),
    .load_use (lu_rs),
    .sel      (sel_rs)
  );

  fwd_select u_fwd_rt (
    .src      (id_rt),
    .use_src  (id_use_rt),
    .em_dest  (em_q.dest),
    .em_we    (em_q.we),
    .em_load  (em_q.load),
    .wb_dest  (wb_q.dest),
    .wb_we    (wb_q.we),
    .load_use (lu_rt),
    .sel      (sel_rt)
  );

  // A pending memory access freezes everything and suppresses the interlock for that cycle
  always_comb begin
    freeze = em_q.mem && mem_busy;
    if (FWD_EN) begin
      interlock = !freeze && (lu_rs || lu_rt);
    end else begin
      interlock = !freeze && (lu_rs || lu_rt || (sel_rs != FWD_RF) || (sel_rt != FWD_RF));
    end
    stall_if     = freeze || interlock;
    stall_id     = freeze || interlock;
    bubble_em    = interlock;
    stall_em     = freeze;
    fwd_a_sel    = FWD_EN ? sel_rs : FWD_RF;
    fwd_b_sel    = FWD_EN ? sel_rt : FWD_RF;
    mem_timeout  = mem_timeout_q;
    stall_cycles = stall_cycles_q;
  end

  always_comb begin
    state_d = RUN;
    if (freeze) begin
      state_d = MEM_WAIT;
    end else if (interlock && FWD_EN) begin
      state_d = LOAD_STALL;
    end

    em_d = em_q;
    wb_d = wb_q;
    if (!freeze) begin
      wb_d.dest = em_q.dest;
      wb_d.we   = em_q.we;
      em_d.dest = id_dest;
      em_d.we   = id_reg_we && !interlock;
      em_d.load = id_mem_re && !interlock;
      em_d.mem  = (id_mem_re || id_mem_we) && !interlock;
    end

    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (state_q == MEM_WAIT) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_d == WAIT_MAX) begin
        mem_timeout_d = 1'b1;
      end
    end

    stall_cycles_d = stall_cycles_q;
    if (stall_if && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      em_q           <= '0;
      wb_q           <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      em_q           <= em_d;
      wb_q           <= wb_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 255;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, id_dest;
  logic             id_use_rs, id_use_rt, id_reg_we, id_mem_re, id_mem_we, mem_busy;
  logic             stall_if, stall_id, bubble_em, stall_em, mem_timeout;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_reg_we    (id_reg_we),
    .id_mem_re    (id_mem_re),
    .id_mem_we    (id_mem_we),
    .mem_busy     (mem_busy),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .bubble_em    (bubble_em),
    .stall_em     (stall_em),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    int rs, rt, urs, urt, dest, we, re, wem, busy;
    int fa, fb, f_st, f_bub, n_st, n_bub, sem;
  } vec_t;

  typedef struct {
    int dest;
    bit we, load, mem;
  } slot_t;

  int    n_cmp, n_bad;
  vec_t  vq[$];
  slot_t m_em, m_wb;
  bit    m_in_wait, m_timeout;
  int    m_wait_len, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs, rt, urs, urt, dest, we, re, wem, busy);
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = urs[0];
    id_use_rt = urt[0];
    id_dest   = 5'(dest);
    id_reg_we = we[0];
    id_mem_re = re[0];
    id_mem_we = wem[0];
    mem_busy  = busy[0];
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t v(input int rs, rt, urs, urt, dest, we, re, wem, busy,
                             input int fa, fb, f_st, f_bub, n_st, n_bub, sem);
    vec_t t;
    t = '{rs, rt, urs, urt, dest, we, re, wem, busy, fa, fb, f_st, f_bub, n_st, n_bub, sem};
    return t;
  endfunction

  function automatic bit hit(input slot_t s, input int r, input bit u);
    return u && s.we && (s.dest == r) && (r != 0);
  endfunction

  task automatic add_nop(input int busy);
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, busy, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    int exp_cnt;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step;
    step;
    @(negedge clock);
    chk("rst_stall_if", 32'(stall_if), 0);
    chk("rst_stall_em", 32'(stall_em), 0);
    chk("rst_bubble", 32'(bubble_em), 0);
    chk("rst_fwd_a", 32'(fwd_a_sel), 0);
    chk("rst_fwd_b", 32'(fwd_b_sel), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    reset = 1'b0;
    step;

    // add $3,$1,$2 ; sub $4,$3,$5
    vq.push_back(v(1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    add_nop(0); add_nop(0);
    // lw $3 ; add $4,$3,$3 presented twice (held in ID)
    vq.push_back(v(1, 3, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    vq.push_back(v(3, 3, 1, 1, 4, 1, 0, 0, 0, 2, 2, 0, 0, 1, 1, 0));
    add_nop(0); add_nop(0);
    // addi $0,$0,5 ; reader of $0
    vq.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_nop(0); add_nop(0);
    // $6 written by both EM and WB: EM wins
    vq.push_back(v(1, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6, 6, 1, 1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0));
    add_nop(0); add_nop(0);
    // sw in EM with mem_busy for 4 cycles
    vq.push_back(v(1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vq.push_back(v(1, 0, 1, 0, 5, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    vq.push_back(v(1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_nop(0); add_nop(0);
    // load-use coinciding with mem_busy
    vq.push_back(v(1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(3, 0, 1, 0, 4, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    vq.push_back(v(3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    vq.push_back(v(3, 0, 1, 0, 4, 1, 0, 0, 0, 2, 0, 0, 0, 1, 1, 0));
    add_nop(0); add_nop(0);
    // mem_busy with no memory op in EM
    add_nop(1);

    exp_cnt = 0;
    foreach (vq[i]) begin
      int e_st, e_bub, e_fa, e_fb;
      drive(vq[i].rs, vq[i].rt, vq[i].urs, vq[i].urt, vq[i].dest,
            vq[i].we, vq[i].re, vq[i].wem, vq[i].busy);
      e_st  = FWD ? vq[i].f_st : vq[i].n_st;
      e_bub = FWD ? vq[i].f_bub : vq[i].n_bub;
      e_fa  = FWD ? vq[i].fa : 0;
      e_fb  = FWD ? vq[i].fb : 0;
      @(negedge clock);
      chk($sformatf("v%0d_stall_if", i), 32'(stall_if), e_st);
      chk($sformatf("v%0d_stall_id", i), 32'(stall_id), e_st);
      chk($sformatf("v%0d_bubble", i), 32'(bubble_em), e_bub);
      chk($sformatf("v%0d_stall_em", i), 32'(stall_em), vq[i].sem);
      chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a_sel), e_fa);
      chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b_sel), e_fb);
      exp_cnt += e_st;
      step;
    end
    chk("tbl_stall_cycles", 32'(stall_cycles), exp_cnt);
    chk("tbl_timeout", 32'(mem_timeout), 0);

    // 300 busy cycles: MEM_WAIT starts one cycle after busy rises
    drive(1, 2, 1, 1, 0, 0, 0, 1, 0);
    step;
    for (int k = 0; k < 300; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clock);
      chk($sformatf("to%0d_timeout", k), 32'(mem_timeout), 32'(k >= MEM_TIMEOUT + 1));
      if (k == 0 || k == 299) chk($sformatf("to%0d_stall_em", k), 32'(stall_em), 1);
      step;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("to_exit_stall_em", 32'(stall_em), 0);
    chk("to_exit_timeout", 32'(mem_timeout), 1);
    chk("to_sat_stall_cycles", 32'(stall_cycles), CNT_MAX);
    step;
    @(negedge clock);
    chk("to_sticky", 32'(mem_timeout), 1);
    step;

    // reset during a memory wait
    drive(1, 2, 1, 1, 0, 0, 0, 1, 0);
    step;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    chk("rs_pre_stall_em", 32'(stall_em), 1);
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    @(negedge clock);
    chk("rs_stall_em", 32'(stall_em), 0);
    chk("rs_stall_if", 32'(stall_if), 0);
    chk("rs_timeout", 32'(mem_timeout), 0);
    chk("rs_stall_cycles", 32'(stall_cycles), 0);

    // randomized traffic against a slot-level model
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step;
    reset = 1'b0;
    m_em = '{0, 0, 0, 0};
    m_wb = '{0, 0, 0, 0};
    m_in_wait = 0; m_timeout = 0; m_wait_len = 0; m_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      int rs, rt, urs, urt, dest, we, op, busy, fa, fb;
      bit ers, wrs, ert, wrt, frz, ilk, sif;
      rs = $urandom_range(0, 3); rt = $urandom_range(0, 3);
      urs = $urandom_range(0, 1); urt = $urandom_range(0, 1);
      dest = $urandom_range(0, 3); we = $urandom_range(0, 1);
      op = $urandom_range(0, 3); busy = ($urandom_range(0, 2) == 0) ? 1 : 0;
      drive(rs, rt, urs, urt, dest, we, (op == 1) ? 1 : 0, (op == 2) ? 1 : 0, busy);
      ers = hit(m_em, rs, urs[0]); wrs = hit(m_wb, rs, urs[0]);
      ert = hit(m_em, rt, urt[0]); wrt = hit(m_wb, rt, urt[0]);
      frz = m_em.mem && (busy != 0);
      if (FWD) begin
        ilk = !frz && m_em.load && (ers || ert);
        fa = (ers && !m_em.load) ? 1 : (wrs ? 2 : 0);
        fb = (ert && !m_em.load) ? 1 : (wrt ? 2 : 0);
      end else begin
        ilk = !frz && (ers || wrs || ert || wrt);
        fa = 0;
        fb = 0;
      end
      sif = frz || ilk;
      @(negedge clock);
      chk($sformatf("r%0d_stall_if", c), 32'(stall_if), 32'(sif));
      chk($sformatf("r%0d_stall_id", c), 32'(stall_id), 32'(sif));
      chk($sformatf("r%0d_bubble", c), 32'(bubble_em), 32'(ilk));
      chk($sformatf("r%0d_stall_em", c), 32'(stall_em), 32'(frz));
      chk($sformatf("r%0d_fwd_a", c), 32'(fwd_a_sel), fa);
      chk($sformatf("r%0d_fwd_b", c), 32'(fwd_b_sel), fb);
      chk($sformatf("r%0d_timeout", c), 32'(mem_timeout), 32'(m_timeout));
      chk($sformatf("r%0d_stall_cycles", c), 32'(stall_cycles), m_cnt);
      if (m_in_wait) begin
        m_wait_len++;
        if (m_wait_len >= MEM_TIMEOUT) m_timeout = 1;
      end else begin
        m_wait_len = 0;
      end
      m_in_wait = frz;
      if (sif && m_cnt < CNT_MAX) m_cnt++;
      if (!frz) begin
        m_wb = m_em;
        m_em = '{dest, (we != 0) && !ilk, (op == 1) && !ilk, (op == 1 || op == 2) && !ilk};
      end
      step;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
